// File: rtl/add_sub_result_checker_pkg.sv
// Shared constants for the adder response checker.
// State encodings and default sizing.
package add_sub_result_checker_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_NUM_VECTORS = 2 ** (2 * DEF_WIDTH + 1);

endpackage

// File: rtl/add_sub_ref_model.sv
// Combinational golden model of the ripple adder.
// Produces {carry, c3, sum} for one operand set.
module add_sub_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic [WIDTH+1:0] res_o
);

  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] low;

  // Full-width sum plus the carry out of bit WIDTH-2
  always_comb begin
    full  = {1'b0, a_i} + {1'b0, b_i}
          + {{WIDTH{1'b0}}, c_in_i};
    low   = {1'b0, a_i[WIDTH-2:0]}
          + {1'b0, b_i[WIDTH-2:0]}
          + {{(WIDTH-1){1'b0}}, c_in_i};
    res_o = {full[WIDTH], low[WIDTH-1],
             full[WIDTH-1:0]};
  end

endmodule

// File: rtl/add_sub_result_checker.sv
// Response checker for the exhaustive adder sweep.
// FSM, order tracking, error counting, first-fail capture.
module add_sub_result_checker
  import add_sub_result_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int IW   = 2 * WIDTH + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  input  logic             c3_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_vld_o,
  output logic [IW-1:0]    fail_idx_o,
  output logic [WIDTH+1:0] fail_got_o
);

  localparam int VW = IW + 1;
  localparam logic [VW-1:0] NUM_V =
    {1'b1, {IW{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    exp_q, exp_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fvld_q, fvld_d;
  logic [IW-1:0]    fidx_q, fidx_d;
  logic [WIDTH+1:0] fgot_q, fgot_d;

  logic [IW-1:0]    idx;
  logic [WIDTH+1:0] got;
  logic [WIDTH+1:0] gold;
  logic             bad;

  assign idx = {c_in_i, a_i, b_i};
  assign got = {carry_i, c3_i, sum_i};

  add_sub_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a_i   (a_i),
    .b_i   (b_i),
    .c_in_i(c_in_i),
    .res_o (gold)
  );

  // A vector fails on a result or an order error
  assign bad = (got != gold) || (idx != exp_q);

  // Next-state: restart, or accept one vector in RUN
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    vcnt_d  = vcnt_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fidx_d  = fidx_q;
    fgot_d  = fgot_q;
    if (start_i) begin
      state_d = ST_RUN;
      exp_d   = '0;
      vcnt_d  = '0;
      err_d   = '0;
      fvld_d  = 1'b0;
      fidx_d  = '0;
      fgot_d  = '0;
    end else if (state_q == ST_RUN && vld_i) begin
      // in order or not, next expected is received+1
      exp_d  = idx + IW'(1);
      vcnt_d = vcnt_q + VW'(1);
      if (bad) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (!fvld_q) begin
          fvld_d = 1'b1;
          fidx_d = idx;
          fgot_d = got;
        end
      end
      if (vcnt_d == NUM_V) state_d = ST_DONE;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      vcnt_q  <= '0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      vcnt_q  <= vcnt_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign done_o     = (state_q == ST_DONE);
  assign pass_o     = done_o && (err_q == '0);
  assign err_cnt_o  = err_q;
  assign fail_vld_o = fvld_q;
  assign fail_idx_o = fidx_q;
  assign fail_got_o = fgot_q;

  // Narrow counters clamp at all-ones
  if (CNT_W >= VW) begin : g_vc_wide
    assign vec_cnt_o = CNT_W'(vcnt_q);
  end else begin : g_vc_sat
    assign vec_cnt_o =
      (vcnt_q > VW'({CNT_W{1'b1}})) ? '1
                                    : vcnt_q[CNT_W-1:0];
  end

endmodule

// File: tb/tb_add_sub_result_checker.sv
// Directed bench for the adder response checker.
// Default instance plus an 8-bit-counter instance.
module tb_add_sub_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vld;
  logic [3:0] a, b, sum;
  logic       c_in, carry, c3;

  logic       busy, done, pass, fvld;
  logic [9:0] vcnt, ecnt;
  logic [8:0] fidx;
  logic [5:0] fgot;

  logic       busy8, done8, pass8, fvld8;
  logic [7:0] vcnt8, ecnt8;
  logic [8:0] fidx8;
  logic [5:0] fgot8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_result_checker dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_i(start), .vld_i(vld),
    .a_i(a), .b_i(b), .c_in_i(c_in),
    .sum_i(sum), .carry_i(carry), .c3_i(c3),
    .busy_o(busy), .done_o(done),
    .pass_o(pass), .vec_cnt_o(vcnt),
    .err_cnt_o(ecnt), .fail_vld_o(fvld),
    .fail_idx_o(fidx), .fail_got_o(fgot)
  );

  add_sub_result_checker #(.CNT_W(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_i(start), .vld_i(vld),
    .a_i(a), .b_i(b), .c_in_i(c_in),
    .sum_i(sum), .carry_i(carry), .c3_i(c3),
    .busy_o(busy8), .done_o(done8),
    .pass_o(pass8), .vec_cnt_o(vcnt8),
    .err_cnt_o(ecnt8), .fail_vld_o(fvld8),
    .fail_idx_o(fidx8), .fail_got_o(fgot8)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // Drive one vector for one cycle, optionally corrupted
  task automatic drive(input logic [8:0] idx,
                       input logic fs,
                       input logic fc3,
                       input logic stb);
    logic [4:0] s;
    logic [3:0] l;
    {c_in, a, b} = idx;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
    l = {1'b0, a[2:0]} + {1'b0, b[2:0]}
      + {3'b0, c_in};
    sum   = s[3:0] ^ {3'b0, fs};
    carry = s[4];
    c3    = l[3] ^ fc3;
    vld   = 1'b1;
    start = stb;
    @(negedge clk);
    vld   = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    vld = 1'b0;
    {a, b, c_in, sum, carry, c3} = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vcnt", vcnt, 0);
    check("rst_ecnt", ecnt, 0);
    check("rst_fvld", fvld, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean sweep
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_vcnt0", vcnt, 0);
    for (int i = 0; i < 512; i++)
      drive(9'(i), 0, 0, 0);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_pass", pass, 1);
    check("t1_vcnt", vcnt, 512);
    check("t1_ecnt", ecnt, 0);
    check("t1_fvld", fvld, 0);
    drive(9'd0, 1, 0, 0);
    check("t1_done_ign", vcnt, 512);
    check("t1_done_ign_e", ecnt, 0);

    // 2: wrong sum at idx 0x0F1
    pulse_start();
    check("t2_clr_done", done, 0);
    for (int i = 0; i < 512; i++)
      drive(9'(i), (i == 'h0F1), 0, 0);
    check("t2_ecnt", ecnt, 1);
    check("t2_fvld", fvld, 1);
    check("t2_fidx", fidx, 9'h0F1);
    check("t2_fgot", fgot, 6'h31);
    check("t2_pass", pass, 0);
    check("t2_done", done, 1);

    // 3: skip idx 5, then resync
    pulse_start();
    for (int i = 0; i < 5; i++)
      drive(9'(i), 0, 0, 0);
    drive(9'd6, 0, 0, 0);
    check("t3_ecnt_skip", ecnt, 1);
    check("t3_fidx", fidx, 9'd6);
    check("t3_vcnt", vcnt, 6);
    drive(9'd7, 0, 0, 0);
    check("t3_resync", ecnt, 1);
    for (int i = 8; i < 512; i++)
      drive(9'(i), 0, 0, 0);
    check("t3_not_done", done, 0);
    drive(9'd0, 0, 0, 0);
    check("t3_done", done, 1);
    check("t3_vcnt_end", vcnt, 512);
    check("t3_ecnt_end", ecnt, 1);

    // 4: corrupt c3 only at idx 0x135
    pulse_start();
    for (int i = 0; i < 512; i++)
      drive(9'(i), 0, (i == 'h135), 0);
    check("t4_ecnt", ecnt, 1);
    check("t4_fidx", fidx, 9'h135);
    check("t4_fgot", fgot, 6'h09);

    // start with vld drops the sample
    pulse_start();
    for (int i = 0; i < 10; i++)
      drive(9'(i), 1, 0, 0);
    check("t7_pre_ecnt", ecnt, 10);
    drive(9'd10, 1, 0, 1);
    check("t7_drop_vcnt", vcnt, 0);
    check("t7_drop_ecnt", ecnt, 0);
    check("t7_drop_fvld", fvld, 0);
    check("t7_busy", busy, 1);
    drive(9'd0, 0, 0, 0);
    check("t7_vcnt1", vcnt, 1);
    check("t7_ecnt1", ecnt, 0);

    // 5: reset mid-sweep
    pulse_start();
    for (int i = 0; i < 200; i++)
      drive(9'(i), (i == 3), 0, 0);
    check("t5_vcnt200", vcnt, 200);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_vcnt", vcnt, 0);
    check("t5_rst_ecnt", ecnt, 0);
    check("t5_rst_fvld", fvld, 0);
    check("t5_rst_fidx", fidx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(9'd0, 0, 0, 0);
    check("t5_idle_ign", vcnt, 0);
    pulse_start();
    for (int i = 0; i < 512; i++)
      drive(9'(i), 0, 0, 0);
    check("t5_pass", pass, 1);
    check("t5_ecnt", ecnt, 0);
    check("t5_vcnt", vcnt, 512);

    // 6: every vector failing
    pulse_start();
    for (int i = 0; i < 512; i++)
      drive(9'(i), 1, 0, 0);
    check("t6_ecnt10", ecnt, 512);
    check("t6_fidx", fidx, 0);
    check("t6_fgot", fgot, 6'h01);
    check("t6_ecnt8", ecnt8, 8'hFF);
    check("t6_vcnt8", vcnt8, 8'hFF);
    check("t6_done8", done8, 1);
    check("t6_pass8", pass8, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
